// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer: board and simulation stability
// thresholds plus the counter-width helper used by every channel.
package sw_debounce_pkg;

    localparam int DB_CYCLES_DEFAULT = 20000;
    localparam int DB_CYCLES_SIM     = 4;

    function automatic int cnt_width(input int db_cycles);
        return $clog2(db_cycles);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, stability counter, accepted
// state bit and registered rise/fall pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int               CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sw;
    logic             r_rise;
    logic             r_fall;

    logic w_mismatch;
    logic w_accept;

    assign w_mismatch = (r_s2 != r_sw);
    assign w_accept   = w_mismatch && (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_sw   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make r_s2 take the old r_s1, giving two real flop stages.
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_rise <= w_accept &  r_s2;
            r_fall <= w_accept & ~r_s2;
            if (w_accept)
                r_sw <= r_s2;
            // Any matching sample throws away the accumulated count.
            if (!w_mismatch || w_accept)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sw     = r_sw;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches; each line is an independent channel and
// sw_chg flags any accepted transition in the same cycle as its pulse.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    logic [WIDTH-1:0] w_accept;
    logic             r_chg;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (sw_raw[i]),
            .o_sw     (sw[i]),
            .o_rise   (sw_rise[i]),
            .o_fall   (sw_fall[i]),
            .o_accept (w_accept[i])
        );
    end

    // Registered from the same acceptance terms that load the pulse flops,
    // so sw_chg lines up with sw_rise/sw_fall.
    always_ff @(posedge clk) begin
        if (rst)
            r_chg <= 1'b0;
        else
            r_chg <= |w_accept;
    end

    assign sw_chg = r_chg;

endmodule
